// File: rtl/tag_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tag_tx_encoder
// Brief    : Tag reply transmitter: pilot, preamble, FM0/Miller data and the
//            trailing dummy 1. Extended pilot honoured only with TX_TREXT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tag_tx_encoder #(
  parameter logic [11:0] FM0_PREAMBLE    = 12'b110100100011,
  parameter logic [5:0]  MILLER_PREAMBLE = 6'b010111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] m,
  input  logic       trext,
  input  logic       start,
  input  logic       tx_bit,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       bit_ack,
  output logic       txout,
  output logic       busy,
  output logic       tx_done,
  output logic       underflow
);

  localparam logic [2:0] c_idle     = 3'd0;
  localparam logic [2:0] c_pilot    = 3'd1;
  localparam logic [2:0] c_preamble = 3'd2;
  localparam logic [2:0] c_data     = 3'd3;
  localparam logic [2:0] c_dummy    = 3'd4;
  localparam logic [2:0] c_done     = 3'd5;

  logic [2:0] r_state, w_state_n;
  logic [1:0] r_mode, w_mode_n;
  logic       r_trext, w_trext_n;
  logic [3:0] r_hcnt, w_hcnt_n;
  logic [4:0] r_pcnt, w_pcnt_n;
  logic       r_bit, w_bit_n;
  logic       r_last, w_last_n;
  logic       r_b, w_b_n;
  logic       r_sc, w_sc_n;
  logic       r_txout, w_txout_n;
  logic       r_bit_ack, w_ack_n;
  logic       r_tx_done;
  logic       r_underflow, w_uf_n;
  logic       w_fetch, w_trext_in, w_fm0, w_bit_end, w_active_n;
  logic [3:0] w_lm1, w_half;
  logic [4:0] w_pilot_last;

`ifdef TX_TREXT_EN
  assign w_trext_in = trext;
`else
  logic w_unused_trext;
  assign w_trext_in     = 1'b0;
  assign w_unused_trext = trext;
`endif

  // Bit length L-1 and mid-bit position L/2 for the latched mode
  always_comb begin
    case (r_mode)
      2'b00:   begin w_lm1 = 4'd1;  w_half = 4'd1; end
      2'b01:   begin w_lm1 = 4'd3;  w_half = 4'd2; end
      2'b10:   begin w_lm1 = 4'd7;  w_half = 4'd4; end
      default: begin w_lm1 = 4'd15; w_half = 4'd8; end
    endcase
  end

  assign w_fm0        = (r_mode == 2'b00);
  assign w_bit_end    = (r_hcnt == w_lm1);
  assign w_pilot_last = r_trext ? 5'd15 : 5'd3;

  always_comb begin
    w_state_n = r_state;
    w_mode_n  = r_mode;
    w_trext_n = r_trext;
    w_hcnt_n  = r_hcnt;
    w_pcnt_n  = r_pcnt;
    w_bit_n   = r_bit;
    w_last_n  = r_last;
    w_uf_n    = r_underflow;
    w_ack_n   = 1'b0;
    w_fetch   = 1'b0;
    case (r_state)
      c_idle: begin
        if (start) begin
          w_mode_n  = m;
          w_trext_n = w_trext_in;
          w_uf_n    = 1'b0;
          w_hcnt_n  = 4'd0;
          w_pcnt_n  = 5'd0;
          w_bit_n   = 1'b0;
          w_state_n = ((m != 2'b00) || w_trext_in) ? c_pilot : c_preamble;
        end
      end
      c_pilot: begin
        if (w_fm0) begin
          if (r_pcnt == 5'd23) begin
            w_state_n = c_preamble;
            w_pcnt_n  = 5'd0;
          end else begin
            w_pcnt_n = r_pcnt + 5'd1;
          end
        end else if (w_bit_end) begin
          w_hcnt_n = 4'd0;
          if (r_pcnt == w_pilot_last) begin
            w_state_n = c_preamble;
            w_pcnt_n  = 5'd0;
            w_bit_n   = MILLER_PREAMBLE[5];
          end else begin
            w_pcnt_n = r_pcnt + 5'd1;
          end
        end else begin
          w_hcnt_n = r_hcnt + 4'd1;
        end
      end
      c_preamble: begin
        if (w_fm0) begin
          if (r_pcnt == 5'd11) w_fetch = 1'b1;
          else                 w_pcnt_n = r_pcnt + 5'd1;
        end else if (w_bit_end) begin
          w_hcnt_n = 4'd0;
          if (r_pcnt == 5'd5) begin
            w_fetch = 1'b1;
          end else begin
            w_pcnt_n = r_pcnt + 5'd1;
            w_bit_n  = MILLER_PREAMBLE[3'd4 - r_pcnt[2:0]];
          end
        end else begin
          w_hcnt_n = r_hcnt + 4'd1;
        end
      end
      c_data: begin
        if (w_bit_end) begin
          w_hcnt_n = 4'd0;
          if (r_last) begin
            w_state_n = c_dummy;
            w_bit_n   = 1'b1;
          end else begin
            w_fetch = 1'b1;
          end
        end else begin
          w_hcnt_n = r_hcnt + 4'd1;
        end
      end
      c_dummy: begin
        if (w_bit_end) w_state_n = c_done;
        else           w_hcnt_n  = r_hcnt + 4'd1;
      end
      default: w_state_n = c_idle;
    endcase

    // An empty source at fetch time ends the reply straight into the dummy 1
    if (w_fetch) begin
      w_hcnt_n = 4'd0;
      if (tx_valid) begin
        w_state_n = c_data;
        w_bit_n   = tx_bit;
        w_last_n  = tx_last;
        w_ack_n   = 1'b1;
      end else begin
        w_state_n = c_dummy;
        w_bit_n   = 1'b1;
        w_uf_n    = 1'b1;
      end
    end
  end

  // Baseband level for the coming half-period; r_bit holds the previous bit
  always_comb begin
    w_active_n = (w_state_n != c_idle) && (w_state_n != c_done);
    w_sc_n     = (r_state == c_idle) ? 1'b0 : ~r_sc;
    w_b_n      = r_b;
    if (!w_active_n)
      w_b_n = 1'b0;
    else if ((w_mode_n == 2'b00) && (w_state_n == c_pilot))
      w_b_n = w_pcnt_n[0];
    else if ((w_mode_n == 2'b00) && (w_state_n == c_preamble))
      w_b_n = FM0_PREAMBLE[4'd11 - w_pcnt_n[3:0]];
    else if (w_state_n == c_pilot)
      w_b_n = 1'b0;
    else if (w_hcnt_n == 4'd0)
      w_b_n = r_b ^ (w_fm0 | (~r_bit & ~w_bit_n));
    else if (w_hcnt_n == w_half)
      w_b_n = r_b ^ (w_fm0 ? ~w_bit_n : w_bit_n);
    w_txout_n = w_active_n & (w_b_n ^ ((w_mode_n != 2'b00) & w_sc_n));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= c_idle;
      r_mode      <= 2'b00;
      r_trext     <= 1'b0;
      r_hcnt      <= 4'd0;
      r_pcnt      <= 5'd0;
      r_bit       <= 1'b0;
      r_last      <= 1'b0;
      r_b         <= 1'b0;
      r_sc        <= 1'b0;
      r_txout     <= 1'b0;
      r_bit_ack   <= 1'b0;
      r_tx_done   <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_mode      <= w_mode_n;
      r_trext     <= w_trext_n;
      r_hcnt      <= w_hcnt_n;
      r_pcnt      <= w_pcnt_n;
      r_bit       <= w_bit_n;
      r_last      <= w_last_n;
      r_b         <= w_b_n;
      r_sc        <= w_sc_n;
      r_txout     <= w_txout_n;
      r_bit_ack   <= w_ack_n;
      r_tx_done   <= (w_state_n == c_done);
      r_underflow <= w_uf_n;
    end
  end

  assign txout     = r_txout;
  assign bit_ack   = r_bit_ack;
  assign tx_done   = r_tx_done;
  assign underflow = r_underflow;
  assign busy      = (r_state != c_idle) && (r_state != c_done);

endmodule
`default_nettype wire

// File: tb/tb_tag_tx_encoder.sv
`default_nettype none
// Directed-reply bench for tag_tx_encoder; waveforms are captured per cycle
// (cycle 1 = first cycle after start) and compared with hand-derived vectors.
module tb_tag_tx_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] m = 2'b00;
  logic       trext = 1'b0;
  logic       start = 1'b0;
  logic       tx_bit = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       bit_ack, txout, busy, tx_done, underflow;

  int checks = 0;
  int errors = 0;

  logic [15:0]  src_bits, src_valid;
  int           src_len, src_idx;
  logic [511:0] cap_tx, cap_ack, cap_busy, cap_done, cap_uf;

  localparam logic [17:0] FS_TX   = {16'b1101_0010_0011_0100, 2'b00};
  localparam logic [17:0] FS_ACK  = 18'h00020;
  localparam logic [17:0] FS_BUSY = 18'h3FFFC;
  localparam logic [17:0] FS_DONE = 18'h00002;
  localparam logic [17:0] UF_TX   = {12'hD23, 2'b00, 2'b11, 2'b00};
  localparam logic [17:0] UF_UF   = 18'h0000F;
  localparam logic [51:0] M2_TX   =
    52'b0101_0101_0101_0101_1010_1001_0101_0110_1001_0110_1001_0101_0110;
`ifdef TX_TREXT_EN
  localparam logic [41:0] FT_TX   = {24'h555555, 12'hD23, 2'b00, 2'b11, 2'b00};
  localparam int          FT_BUSY = 40;
  localparam int          FT_DONE = 41;
  localparam int          M8_ACK0 = 353;
  localparam int          M8_BUSY = 416;
`else
  localparam logic [41:0] FT_TX   = {12'hD23, 2'b00, 2'b11, 26'd0};
  localparam int          FT_BUSY = 16;
  localparam int          FT_DONE = 17;
  localparam int          M8_ACK0 = 161;
  localparam int          M8_BUSY = 224;
`endif

  tag_tx_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .m         (m),
    .trext     (trext),
    .start     (start),
    .tx_bit    (tx_bit),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .bit_ack   (bit_ack),
    .txout     (txout),
    .busy      (busy),
    .tx_done   (tx_done),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_src();
    if (src_idx < 16) begin
      tx_bit   = src_bits[src_idx];
      tx_valid = src_valid[src_idx];
    end else begin
      tx_bit   = 1'b0;
      tx_valid = 1'b0;
    end
    tx_last = (src_idx == src_len - 1);
  endtask

  task automatic set_src(input logic [15:0] bits, input logic [15:0] valid, input int len);
    src_bits  = bits;
    src_valid = valid;
    src_len   = len;
  endtask

  task automatic do_start(input logic [1:0] mm, input logic tt);
    @(negedge clk);
    m       = mm;
    trext   = tt;
    start   = 1'b1;
    src_idx = 0;
    drive_src();
  endtask

  // Record n cycles; the source advances one cycle after each bit_ack.
  // m/trext are scrambled after start to show they were latched.
  task automatic capture(input int n, input int restart_at);
    logic pend;
    pend     = 1'b0;
    cap_tx   = '0;
    cap_ack  = '0;
    cap_busy = '0;
    cap_done = '0;
    cap_uf   = '0;
    for (int k = 1; k <= n; k++) begin
      if (pend) begin
        @(posedge clk);
        #1;
        src_idx++;
        drive_src();
      end
      @(negedge clk);
      cap_tx   = {cap_tx[510:0], txout};
      cap_ack  = {cap_ack[510:0], bit_ack};
      cap_busy = {cap_busy[510:0], busy};
      cap_done = {cap_done[510:0], tx_done};
      cap_uf   = {cap_uf[510:0], underflow};
      pend     = bit_ack;
      if (k == 1) begin
        start = 1'b0;
        m     = ~m;
        trext = ~trext;
      end
      if (k == restart_at) start = 1'b1;
      if ((restart_at > 0) && (k == restart_at + 1)) start = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({txout, busy, bit_ack, tx_done, underflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b required 00000",
               {txout, busy, bit_ack, tx_done, underflow});
    end
    reset = 1'b0;
  endtask

  task automatic test_fm0_short();
    set_src(16'h0000, 16'h0001, 1);
    do_start(2'b00, 1'b0);
    capture(18, 0);
    checks++;
    if (cap_tx[17:0] !== FS_TX) begin
      errors++; $display("FAIL fm0_short_txout got %b required %b", cap_tx[17:0], FS_TX);
    end
    checks++;
    if (cap_ack[17:0] !== FS_ACK) begin
      errors++; $display("FAIL fm0_short_ack got %b required %b", cap_ack[17:0], FS_ACK);
    end
    checks++;
    if (cap_busy[17:0] !== FS_BUSY) begin
      errors++; $display("FAIL fm0_short_busy got %b required %b", cap_busy[17:0], FS_BUSY);
    end
    checks++;
    if (cap_done[17:0] !== FS_DONE) begin
      errors++; $display("FAIL fm0_short_done got %b required %b", cap_done[17:0], FS_DONE);
    end
  endtask

  task automatic test_fm0_trext();
    set_src(16'h0001, 16'h0001, 1);
    do_start(2'b00, 1'b1);
    capture(42, 0);
    checks++;
    if (cap_tx[41:0] !== FT_TX) begin
      errors++; $display("FAIL fm0_trext_txout got %b required %b", cap_tx[41:0], FT_TX);
    end
    checks++;
    if ($countones(cap_busy) != FT_BUSY) begin
      errors++; $display("FAIL fm0_trext_busy got %0d required %0d", $countones(cap_busy), FT_BUSY);
    end
    checks++;
    if (cap_done[42 - FT_DONE] !== 1'b1 || $countones(cap_done) != 1) begin
      errors++; $display("FAIL fm0_trext_done got %b required single pulse at cycle %0d",
                         cap_done[41:0], FT_DONE);
    end
  endtask

  task automatic test_miller2();
    logic [53:0] exp_ack;
    exp_ack     = '0;
    exp_ack[13] = 1'b1;
    exp_ack[9]  = 1'b1;
    set_src(16'h0001, 16'h0003, 2);
    do_start(2'b01, 1'b0);
    capture(54, 0);
    checks++;
    if (cap_tx[53:2] !== M2_TX) begin
      errors++; $display("FAIL miller2_txout got %b required %b", cap_tx[53:2], M2_TX);
    end
    checks++;
    if (cap_ack[53:0] !== exp_ack) begin
      errors++; $display("FAIL miller2_ack got %b required %b", cap_ack[53:0], exp_ack);
    end
    checks++;
    if (cap_busy[53:0] !== {{52{1'b1}}, 2'b00}) begin
      errors++; $display("FAIL miller2_busy got %b required 52 ones then 00", cap_busy[53:0]);
    end
    checks++;
    if (cap_done[53:0] !== 54'd2 || cap_tx[1] !== 1'b0) begin
      errors++; $display("FAIL miller2_done got done=%b txout53=%b required done at 53, txout 0",
                         cap_done[53:0], cap_tx[1]);
    end
  endtask

  task automatic test_miller8();
    set_src(16'h0005, 16'h0007, 3);
    do_start(2'b11, 1'b1);
    capture(420, 0);
    checks++;
    if (cap_tx[419 -: 16] !== 16'h5555) begin
      errors++; $display("FAIL miller8_pilot got %h required 5555", cap_tx[419 -: 16]);
    end
    checks++;
    if ({cap_ack[420 - M8_ACK0], cap_ack[420 - M8_ACK0 - 16], cap_ack[420 - M8_ACK0 - 32]} !== 3'b111
        || $countones(cap_ack) != 3) begin
      errors++; $display("FAIL miller8_ack got %0d pulses, required 3 at %0d spaced 16",
                         $countones(cap_ack), M8_ACK0);
    end
    checks++;
    if ($countones(cap_busy) != M8_BUSY) begin
      errors++; $display("FAIL miller8_busy got %0d required %0d", $countones(cap_busy), M8_BUSY);
    end
    checks++;
    if (cap_done[420 - M8_BUSY - 1] !== 1'b1) begin
      errors++; $display("FAIL miller8_done got 0 required 1 at cycle %0d", M8_BUSY + 1);
    end
  endtask

  task automatic test_underflow();
    set_src(16'h0001, 16'h0001, 3);
    do_start(2'b00, 1'b0);
    capture(18, 0);
    checks++;
    if (cap_tx[17:0] !== UF_TX) begin
      errors++; $display("FAIL uf_txout got %b required %b", cap_tx[17:0], UF_TX);
    end
    checks++;
    if (cap_uf[17:0] !== UF_UF) begin
      errors++; $display("FAIL uf_flag got %b required %b", cap_uf[17:0], UF_UF);
    end
    checks++;
    if (cap_ack[17:0] !== FS_ACK || cap_done[17:0] !== FS_DONE) begin
      errors++; $display("FAIL uf_ack_done got ack=%b done=%b required %b %b",
                         cap_ack[17:0], cap_done[17:0], FS_ACK, FS_DONE);
    end
    checks++;
    if (underflow !== 1'b1) begin
      errors++; $display("FAIL uf_sticky got %b required 1", underflow);
    end
    do_start(2'b00, 1'b0);
    capture(18, 0);
    checks++;
    if (cap_uf[17:0] !== UF_UF) begin
      errors++; $display("FAIL uf_start_clear got %b required %b", cap_uf[17:0], UF_UF);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (underflow !== 1'b0) begin
      errors++; $display("FAIL uf_reset_clear got %b required 0", underflow);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_data();
    set_src(16'h000F, 16'h000F, 4);
    do_start(2'b01, 1'b0);
    capture(41, 0);
    checks++;
    if ({cap_ack[0], cap_busy[0], cap_tx[0]} !== 3'b111) begin
      errors++; $display("FAIL mid_data_pre got ack/busy/txout=%b required 111",
                         {cap_ack[0], cap_busy[0], cap_tx[0]});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({txout, busy, bit_ack, tx_done, underflow} !== 5'b0) begin
      errors++; $display("FAIL mid_data_async got %b required 00000",
                         {txout, busy, bit_ack, tx_done, underflow});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    set_src(16'h0000, 16'h0001, 1);
    do_start(2'b00, 1'b0);
    capture(18, 5);
    checks++;
    if (cap_tx[17:0] !== FS_TX) begin
      errors++; $display("FAIL restart_txout got %b required %b", cap_tx[17:0], FS_TX);
    end
    checks++;
    if (cap_busy[17:0] !== FS_BUSY) begin
      errors++; $display("FAIL restart_busy got %b required %b", cap_busy[17:0], FS_BUSY);
    end
    checks++;
    if (cap_done[17:0] !== FS_DONE || cap_ack[17:0] !== FS_ACK) begin
      errors++; $display("FAIL restart_done_ack got done=%b ack=%b required %b %b",
                         cap_done[17:0], cap_ack[17:0], FS_DONE, FS_ACK);
    end
  endtask

  initial begin
    test_reset();
    test_fm0_short();
    test_fm0_trext();
    test_miller2();
    test_miller8();
    test_underflow();
    test_reset_mid_data();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tag_tx_encoder.md
Name: tag_tx_encoder

Overview:
- Tag-to-reader reply transmitter: the backscatter counterpart of the reader-command parser.
- Takes the modulation settings latched from Query (m, trext) plus a serial reply bitstream from the packet source.
- Emits pilot, preamble, FM0- or Miller-encoded data, and the end-of-signalling dummy 1 on one modulator output.
- Sits between the reply packet mux and the backscatter modulator driver.

Parameters:
- FM0_PREAMBLE, 12'b110100100011: FM0 preamble half-period levels, MSB first.
- MILLER_PREAMBLE, 6'b010111: Miller preamble data bits, MSB first.

Ports:
- clk  input  1  half-BLF-period clock; one cycle = one half subcarrier period.
- reset  input  1  asynchronous, active-high reset.
- m  input  2  00 FM0, 01 Miller M=2, 10 M=4, 11 M=8; sampled at start.
- trext  input  1  1 = extended pilot; sampled at start.
- start  input  1  single-cycle request to begin a reply.
- tx_bit  input  1  current data bit from the source.
- tx_valid  input  1  tx_bit is valid.
- tx_last  input  1  tx_bit is the final data bit.
- bit_ack  output  1  one-cycle pulse; current tx_bit consumed.
- txout  output  1  modulator drive level.
- busy  output  1  high from the cycle after start until tx_done.
- tx_done  output  1  one-cycle pulse after the last dummy half-period.
- underflow  output  1  sticky; set when tx_valid is low at a data-bit fetch. Cleared by start or reset.

Behaviour:
- Reset state: txout=0, busy=0, bit_ack=0, tx_done=0, underflow=0, FSM=IDLE. Reset mid-reply aborts immediately to these values.
- FSM states: IDLE -> PILOT -> PREAMBLE -> DATA -> DUMMY -> DONE -> IDLE.
- start in IDLE latches m and trext. First txout half-period is the next clk edge. start while busy is ignored.
- Bit length: L=2 clk cycles for FM0, 2M cycles for Miller.
- FM0 encoding:
  - txout inverts at every bit boundary.
  - A data 0 also inverts at mid-bit.
- FM0 PILOT and PREAMBLE:
  - PILOT only when trext=1: 24 half-periods alternating L,H,...,ending H.
  - PREAMBLE: FM0_PREAMBLE levels verbatim, one per clk.
  - The first data bit's boundary inversion is relative to the last preamble level (H).
- Miller baseband encoding:
  - Baseband b inverts mid-bit for a data 1.
  - Baseband b inverts at a boundary only between two consecutive 0s.
  - txout = b XOR sc; sc starts 0 at PILOT entry and toggles every clk.
- Miller PILOT and PREAMBLE:
  - PILOT: 4 zero bits (16 if trext) with b held constant at 0. Pilot zeros do not invert each other.
  - PREAMBLE: MILLER_PREAMBLE encoded with the normal rules, preceded by the last pilot 0.
- DATA fetch:
  - At the first cycle of each data bit, tx_bit is sampled and bit_ack pulses that same cycle.
  - The source advances tx_bit/tx_last on the cycle after bit_ack.
  - After the bit whose tx_last=1 is sent, go to DUMMY.
- Underflow: if tx_valid=0 at a fetch, set underflow, send no further data, go to DUMMY.
- DUMMY: one data-1 bit with the current mode's rules.
- DONE: tx_done pulses for one cycle, txout=0, busy drops the same cycle. Next cycle is IDLE.
- A zero-length reply is not supported. The source must present valid data by the first DATA fetch.
- Counters:
  - Half-period counter is 4 bits and wraps at 2M-1 (1 for FM0).
  - Pilot/preamble counter is 5 bits.
  - No data length limit.

Optional Feature:
- Macro TX_TREXT_EN.
- Defined: trext is honoured as above.
- Undefined: trext is ignored and treated as 0 (short pilot only). FM0 PILOT state is never entered. The trext port remains but is unused.

Test Plan:
- FM0, trext=0, one data bit 0 (tx_last=1):
  - txout over 16 cycles = 110100100011 01 00.
  - bit_ack at cycle 13.
  - tx_done one cycle after the last half-period, then txout=0.
- FM0, trext=1, data 1:
  - 24 alternating pilot half-periods (LH...H), then preamble, data 1 = LL, dummy 1 = HH.
  - busy high for 40 cycles.
- Miller M=2, trext=0, data 1,0:
  - Pilot 16 cycles, preamble 24 cycles, data 8, dummy 4; total busy 52 cycles.
  - txout equals a golden model of b XOR sc.
  - bit_ack at cycles 41 and 45.
- Miller M=8, trext=1:
  - Pilot 16 bits = 256 cycles.
  - bit_ack spacing 16 cycles.
- tx_valid=0 at the second fetch:
  - underflow=1, dummy sent immediately, tx_done pulses.
  - Next start clears underflow.
- Reset asserted mid-DATA:
  - txout, busy, bit_ack, tx_done, underflow all 0 asynchronously.
  - start two cycles after release begins a clean reply.
  - start pulsed while busy has no effect.
